// File: rtl/mem_access_unit.sv
// Memory stage between Ex/Mem and Mem/WB: loads, stores, PUSH/POP on a 16-bit data memory,
// owns the stack pointer, and splits 32-bit accesses into two memory cycles.
module mem_access_unit #(
    parameter int          AW      = 12,
    parameter int          WbSize  = 2,
    parameter logic [31:0] SP_INIT = (32'd1 << AW) - 32'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [2:0]        i_MemOp,
    input  logic              i_wide,
    input  logic [15:0]       i_alu,
    input  logic [31:0]       i_wdata,
    input  logic [2:0]        i_Rdst,
    input  logic [WbSize-1:0] i_WB,
    input  logic [15:0]       i_mem_rdata,
    output logic [AW-1:0]     o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic              o_stall,
    output logic [WbSize-1:0] o_WB,
    output logic [31:0]       o_MemData,
    output logic [15:0]       o_alu,
    output logic [2:0]        o_Rdst,
    output logic [31:0]       o_SP,
    output logic              o_state
);

    typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_PUSH  = 3'd3;
    localparam logic [2:0] OP_POP   = 3'd4;

    state_t      state, state_nx;
    logic [31:0] sp, sp_nx, sp_p1, sp_m1;
    logic [15:0] lo_q, lo_nx;
    logic [AW-1:0] a, a_p1;
    logic        live;

    // Handshake: i_valid qualifies the instruction; o_stall is an inverted ready, so an
    // instruction is consumed on the cycle where i_valid=1 and o_stall=0. While o_stall=1
    // the upstream holds every i_* stable. Reset gating makes the stage a no-op in reset.
    assign live  = rst && i_valid && (i_MemOp >= OP_LOAD) && (i_MemOp <= OP_POP);
    assign a     = i_alu[AW-1:0];
    assign a_p1  = a + {{(AW-1){1'b0}}, 1'b1};
    assign sp_p1 = sp + 32'd1;
    assign sp_m1 = sp - 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sp    <= SP_INIT;
            lo_q  <= 16'h0;
        end else begin
            state <= state_nx;
            sp    <= sp_nx;
            lo_q  <= lo_nx;
        end
    end

    always_comb begin
        state_nx    = IDLE;
        sp_nx       = sp;
        lo_nx       = lo_q;
        o_mem_addr  = '0;
        o_mem_wdata = 16'h0;
        o_mem_we    = 1'b0;
        o_mem_re    = 1'b0;
        o_stall     = 1'b0;
        o_WB        = '0;
        o_MemData   = 32'h0;
        if (live) begin
            if (!i_wide) begin
                o_WB = i_WB;
                case (i_MemOp)
                    OP_LOAD:  begin o_mem_addr = a; o_mem_re = 1'b1; o_MemData = {16'h0, i_mem_rdata}; end
                    OP_STORE: begin o_mem_addr = a; o_mem_we = 1'b1; o_mem_wdata = i_wdata[15:0]; end
                    OP_PUSH:  begin
                        o_mem_addr = sp[AW-1:0]; o_mem_we = 1'b1; o_mem_wdata = i_wdata[15:0]; sp_nx = sp_m1;
                    end
                    OP_POP:   begin
                        o_mem_addr = sp_p1[AW-1:0]; o_mem_re = 1'b1; o_MemData = {16'h0, i_mem_rdata}; sp_nx = sp_p1;
                    end
                    default: ;
                endcase
            end else if (state == IDLE) begin
                // First half of a wide access: push stores the high word first so the low word lands lower.
                o_stall  = 1'b1;
                state_nx = SECOND;
                case (i_MemOp)
                    OP_LOAD:  begin o_mem_addr = a; o_mem_re = 1'b1; lo_nx = i_mem_rdata; end
                    OP_STORE: begin o_mem_addr = a; o_mem_we = 1'b1; o_mem_wdata = i_wdata[15:0]; end
                    OP_PUSH:  begin
                        o_mem_addr = sp[AW-1:0]; o_mem_we = 1'b1; o_mem_wdata = i_wdata[31:16]; sp_nx = sp_m1;
                    end
                    OP_POP:   begin
                        o_mem_addr = sp_p1[AW-1:0]; o_mem_re = 1'b1; lo_nx = i_mem_rdata; sp_nx = sp_p1;
                    end
                    default: ;
                endcase
            end else begin
                o_WB = i_WB;
                case (i_MemOp)
                    OP_LOAD:  begin o_mem_addr = a_p1; o_mem_re = 1'b1; o_MemData = {i_mem_rdata, lo_q}; end
                    OP_STORE: begin o_mem_addr = a_p1; o_mem_we = 1'b1; o_mem_wdata = i_wdata[31:16]; end
                    OP_PUSH:  begin
                        o_mem_addr = sp[AW-1:0]; o_mem_we = 1'b1; o_mem_wdata = i_wdata[15:0]; sp_nx = sp_m1;
                    end
                    OP_POP:   begin
                        o_mem_addr = sp_p1[AW-1:0]; o_mem_re = 1'b1; o_MemData = {i_mem_rdata, lo_q}; sp_nx = sp_p1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_SP    = sp_nx;
    assign o_alu   = i_alu;
    assign o_Rdst  = i_Rdst;
    assign o_state = (state == SECOND);

endmodule
